// File: rtl/rr_stream_arbiter_if.sv
// rr_stream_arbiter_if: bundles the requester-side and egress-side stream
// signals of rr_stream_arbiter.
//   in_data   : NUM_INPUTS packed payloads; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_last   : per-requester end-of-packet flag
//   in_valid  : per-requester valid
//   in_ready  : per-requester ready (at most one bit set)
//   out_data  : arbitrated payload
//   out_last  : end-of-packet flag of the current output beat
//   out_sel   : index of the requester that sourced the current output beat
//   out_valid : output valid
//   out_ready : downstream ready
// master = the side that feeds requesters and sinks the output; slave = arbiter.
interface rr_stream_arbiter_if #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) ();
  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_INPUTS-1:0]            in_last;
  logic [NUM_INPUTS-1:0]            in_valid;
  logic [NUM_INPUTS-1:0]            in_ready;
  logic [DATA_WIDTH-1:0]            out_data;
  logic                             out_last;
  logic [SEL_WIDTH-1:0]             out_sel;
  logic                             out_valid;
  logic                             out_ready;

  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_sel, out_valid
  );
endinterface

// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: packet-locked round-robin arbiter sharing one valid/ready
// stream among NUM_INPUTS requesters. The output is registered through a
// two-entry skid_buffer (also defined here) for full throughput while locked.
//   clk     : single clock, posedge
//   reset_n : asynchronous active-low reset
//   bus     : rr_stream_arbiter_if.slave (requester inputs, arbitrated output)
// skid_buffer ports: clk, reset (active high), in_data/in_valid/in_ready,
// out_data/out_valid/out_ready.

module skid_buffer #(
  parameter int DATA_WIDTH      = 8,
  parameter int USE_ASYNC_RESET = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  // Ready depends only on a flop, so no combinational path from out_ready.
  assign in_ready  = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_valid;
        if (in_valid) out_data_d = in_data;
      end
    end else if (in_valid && !skid_valid_q) begin
      // Output stalled: park the accepted beat in the skid slot.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  if (USE_ASYNC_RESET != 0) begin : g_async_rst
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_valid_q  <= 1'b0;
        out_data_q   <= '0;
        skid_valid_q <= 1'b0;
        skid_data_q  <= '0;
      end else begin
        out_valid_q  <= out_valid_d;
        out_data_q   <= out_data_d;
        skid_valid_q <= skid_valid_d;
        skid_data_q  <= skid_data_d;
      end
    end
  end else begin : g_sync_rst
    always_ff @(posedge clk) begin
      if (reset) begin
        out_valid_q  <= 1'b0;
        out_data_q   <= '0;
        skid_valid_q <= 1'b0;
        skid_data_q  <= '0;
      end else begin
        out_valid_q  <= out_valid_d;
        out_data_q   <= out_data_d;
        skid_valid_q <= skid_valid_d;
        skid_data_q  <= skid_data_d;
      end
    end
  end
endmodule

module rr_stream_arbiter #(
  parameter int NUM_INPUTS   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int LOCK_PACKETS = 1,
  parameter int SEL_WIDTH    = $clog2(NUM_INPUTS)
) (
  input logic                clk,
  input logic                reset_n,
  rr_stream_arbiter_if.slave bus
);
  localparam int SKW = DATA_WIDTH + 1 + SEL_WIDTH;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]  grant_q, grant_d;
  logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

  logic [DATA_WIDTH-1:0] req_data [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] in_ready_c;
  logic                  sk_in_valid, sk_in_ready;
  logic [SKW-1:0]        sk_in_data, sk_out_data;
  logic                  eff_last;
  logic                  found;
  int unsigned           idx;
  logic [SEL_WIDTH-1:0]  cand;

  always_comb begin
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      req_data[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Without packet locking every beat closes its "packet".
  assign eff_last = bus.in_last[grant_q] || (LOCK_PACKETS == 0);

  // sel travels with the beat so it stays correct after the grant moves on.
  assign sk_in_data = {grant_q, bus.in_last[grant_q], req_data[grant_q]};

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    in_ready_c  = '0;
    sk_in_valid = 1'b0;
    found       = 1'b0;
    idx         = 0;
    cand        = '0;
    case (state_q)
      IDLE: begin
        // First valid requester at or after rr_ptr, wrapping.
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
          idx = 32'(rr_ptr_q) + k;
          if (idx >= 32'(NUM_INPUTS)) idx = idx - 32'(NUM_INPUTS);
          cand = SEL_WIDTH'(idx);
          if (!found && bus.in_valid[cand]) begin
            found   = 1'b1;
            grant_d = cand;
          end
        end
        if (found) state_d = LOCKED;
      end
      LOCKED: begin
        sk_in_valid         = bus.in_valid[grant_q];
        in_ready_c[grant_q] = sk_in_ready;
        if (sk_in_valid && sk_in_ready && eff_last) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == SEL_WIDTH'(NUM_INPUTS-1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.in_ready = in_ready_c;

  skid_buffer #(
    .DATA_WIDTH      (SKW),
    .USE_ASYNC_RESET (1)
  ) u_skid (
    .clk       (clk),
    .reset     (!reset_n),
    .in_data   (sk_in_data),
    .in_valid  (sk_in_valid),
    .in_ready  (sk_in_ready),
    .out_data  (sk_out_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

  assign {bus.out_sel, bus.out_last, bus.out_data} = sk_out_data;
endmodule
